vslide_seq: RTL and testbench
=============================

Name: vslide_seq

Overview:
- Command sequencer directly upstream of the vector slide pipeline. It accepts one slide1up/slide1down command and issues the source-register word reads.
- Each returned word is forwarded as one slide beat, with start/end flags, shift, insert scalar, byte enables and destination address.
- The slide pipeline has no backpressure, so this block alone paces the beats and guarantees in-order delivery.

Parameters:
- REQ_DATA_WIDTH, 64, width of one vector word in bits.
- REQ_ADDR_WIDTH, 32, width of the word address.
- REQ_BYTE_EN_WIDTH, 8, bytes per word (REQ_DATA_WIDTH/8).
- SHIFT_WIDTH, 3, width of the slide shift field: $clog2(REQ_BYTE_EN_WIDTH).
- VL_WIDTH, 12, width of the vector length / element offset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_opsel  in  1  0 = slide up, 1 = slide down.
- cmd_insert  in  1  insert cmd_scalar at the vacated element.
- cmd_sew  in  2  element width: 0 = 8b, 1 = 16b, 2 = 32b, 3 = 64b.
- cmd_vl  in  VL_WIDTH  element count.
- cmd_off  in  VL_WIDTH  element offset, passed through on every beat.
- cmd_src_addr  in  REQ_ADDR_WIDTH  first source word address.
- cmd_dst_addr  in  REQ_ADDR_WIDTH  first destination word address.
- cmd_scalar  in  REQ_DATA_WIDTH  scalar to insert.
- rd_req_valid  out  1  read request.
- rd_req_ready  in  1  read port accepts the request.
- rd_req_addr  out  REQ_ADDR_WIDTH  read word address.
- rd_resp_valid  in  1  read data valid; responses return in order, any latency.
- rd_resp_data  in  REQ_DATA_WIDTH  read data.
- sl_valid, sl_vec0, sl_vec1, sl_shift, sl_start, sl_end, sl_opsel, sl_insert, sl_addr, sl_be, sl_off  out  slide-beat bundle (widths 1, DATA, DATA, SHIFT_WIDTH, 1, 1, 1, 1, ADDR, BE, VL_WIDTH).
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (async, rst=1):
  - all outputs go to 0, except cmd_ready = 1.
  - state = IDLE; all counters and command registers = 0.
  - An assertion mid-command aborts the command; no further beats or done pulse are produced.
- Command latch:
  - A command is accepted on cmd_valid & cmd_ready.
  - All cmd_* fields are latched; cmd_ready drops in the next cycle.
  - total_bytes = cmd_vl << cmd_sew.
  - nbeats = ceil(total_bytes / REQ_BYTE_EN_WIDTH).
- Shift encoding (sl_shift): sew 0 -> 1, sew 1 -> 2, sew 2 -> 4, sew 3 -> 0 (0 means an 8-byte shift).
- State machine:
  - IDLE -> ISSUE when a command is accepted with vl != 0.
  - IDLE -> DONE when a command is accepted with vl == 0; no reads and no beats are issued.
  - ISSUE: rd_req_valid = 1 while req_cnt < nbeats. rd_req_addr = src + req_cnt. req_cnt increments on rd_req_valid & rd_req_ready.
  - ISSUE -> DRAIN when the last request is accepted.
  - DRAIN -> DONE when resp_cnt == nbeats after the last beat is sent.
  - DONE: done = 1 for one cycle, then go to IDLE with cmd_ready = 1.
- Beat formation:
  - rd_resp_valid in cycle N produces sl_valid = 1 in cycle N+1 (registered, 1-cycle latency). resp_cnt then increments.
  - Responses may arrive while still in ISSUE; they are handled the same way.
  - sl_vec0 = rd_resp_data; sl_addr = dst + resp_cnt.
  - sl_start = (resp_cnt == 0); sl_end = (resp_cnt == nbeats-1). Both are 1 for a single-beat command.
  - sl_vec1 = cmd_scalar; sl_opsel, sl_insert and sl_off are the latched command values.
  - sl_be is all ones, except on the last beat: the low (total_bytes mod REQ_BYTE_EN_WIDTH) bits are set, or all ones when that remainder is 0.
  - All sl_* fields are 0 whenever sl_valid = 0.
- Boundaries:
  - rd_resp_valid in IDLE or DONE is ignored.
  - A response that would exceed nbeats is ignored.
  - A response and a request acceptance in the same cycle are both processed.
  - total_bytes uses VL_WIDTH+3 bits and does not wrap.
  - Stalls on rd_req_ready hold rd_req_addr stable.

Optional Feature:
- Macro VSLIDE_SEQ_PERF_EN.
- Defined:
  - adds output perf_stall_cnt [31:0], counting cycles in ISSUE with rd_req_valid & ~rd_req_ready.
  - the counter saturates at 0xFFFFFFFF.
  - it is cleared by rst and when a command is accepted.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- sew=0, vl=8, opsel=0, insert=1, scalar=0xAB, src=0x10, dst=0x20, rd_req_ready=1, 2-cycle read latency -> one read at 0x10; one beat with start=end=1, shift=1, be=0xFF, addr=0x20, vec1=0xAB; done pulses one cycle after the beat.
- sew=2, vl=5, opsel=1 -> 3 reads at src..src+2; beats: start only, neither, end only; shift=4; be=0xFF, 0xFF, 0x0F; addresses dst..dst+2.
- sew=3, vl=3 with rd_req_ready toggling 1,0,0,1,1 -> rd_req_addr held during the stall; 3 beats with shift=0; with the macro defined, perf_stall_cnt=2.
- vl=0 -> no rd_req_valid, no sl_valid; done on the cycle after acceptance; cmd_ready returns to 1.
- rst asserted after the 2nd of 4 beats -> outputs go to 0 immediately; no further beats or done; a new command is accepted normally afterwards.
- rd_resp_valid asserted in IDLE with data 0x55 -> no sl_valid, no state change.

Source files
------------

// File: rtl/vslide_seq.sv
// rtl/vslide_seq.sv - slide1up/slide1down command sequencer: issues source word reads, emits ordered slide beats
// Optional stall counter output perf_stall_cnt enabled by `define VSLIDE_SEQ_PERF_EN.
module vslide_seq #(
    parameter int REQ_DATA_WIDTH    = 64,
    parameter int REQ_ADDR_WIDTH    = 32,
    parameter int REQ_BYTE_EN_WIDTH = 8,
    parameter int SHIFT_WIDTH       = 3,
    parameter int VL_WIDTH          = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_opsel,
    input  logic                         cmd_insert,
    input  logic [1:0]                   cmd_sew,
    input  logic [VL_WIDTH-1:0]          cmd_vl,
    input  logic [VL_WIDTH-1:0]          cmd_off,
    input  logic [REQ_ADDR_WIDTH-1:0]    cmd_src_addr,
    input  logic [REQ_ADDR_WIDTH-1:0]    cmd_dst_addr,
    input  logic [REQ_DATA_WIDTH-1:0]    cmd_scalar,
    output logic                         rd_req_valid,
    input  logic                         rd_req_ready,
    output logic [REQ_ADDR_WIDTH-1:0]    rd_req_addr,
    input  logic                         rd_resp_valid,
    input  logic [REQ_DATA_WIDTH-1:0]    rd_resp_data,
    output logic                         sl_valid,
    output logic [REQ_DATA_WIDTH-1:0]    sl_vec0,
    output logic [REQ_DATA_WIDTH-1:0]    sl_vec1,
    output logic [SHIFT_WIDTH-1:0]       sl_shift,
    output logic                         sl_start,
    output logic                         sl_end,
    output logic                         sl_opsel,
    output logic                         sl_insert,
    output logic [REQ_ADDR_WIDTH-1:0]    sl_addr,
    output logic [REQ_BYTE_EN_WIDTH-1:0] sl_be,
    output logic [VL_WIDTH-1:0]          sl_off,
    output logic                         done
`ifdef VSLIDE_SEQ_PERF_EN
    ,
    output logic [31:0]                  perf_stall_cnt
`endif
);
    // Byte count needs 3 extra bits so vl << 3 never wraps.
    localparam int TB_W = VL_WIDTH + 3;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_next;

    logic                         opsel_q, insert_q;
    logic [SHIFT_WIDTH-1:0]       shift_q;
    logic [VL_WIDTH-1:0]          off_q;
    logic [REQ_ADDR_WIDTH-1:0]    src_q, dst_q;
    logic [REQ_DATA_WIDTH-1:0]    scalar_q;
    logic [TB_W-1:0]              nbeats_q, req_cnt, resp_cnt;
    logic [REQ_BYTE_EN_WIDTH-1:0] last_be_q;

    logic                         accept, req_pending, req_fire, resp_take, last_resp;
    logic [TB_W-1:0]              total_bytes, nbeats_in;
    logic [SHIFT_WIDTH-1:0]       rem, shift_in;
    logic [REQ_BYTE_EN_WIDTH-1:0] last_be_in;

    assign accept      = cmd_valid & cmd_ready;
    assign total_bytes = TB_W'(cmd_vl) << cmd_sew;
    assign rem         = total_bytes[SHIFT_WIDTH-1:0];
    assign nbeats_in   = (total_bytes >> SHIFT_WIDTH) + TB_W'(rem != '0);
    assign req_pending = (state == ISSUE) && (req_cnt < nbeats_q);
    assign req_fire    = req_pending & rd_req_ready;
    assign resp_take   = rd_resp_valid && ((state == ISSUE) || (state == DRAIN)) && (resp_cnt < nbeats_q);
    assign last_resp   = (resp_cnt == nbeats_q - TB_W'(1));

    always_comb begin
        last_be_in = '0;
        for (int i = 0; i < REQ_BYTE_EN_WIDTH; i++)
            last_be_in[i] = (rem == '0) || (i < int'(rem));
    end

    // A shift of 0 stands for a full 8-byte element.
    always_comb begin
        case (cmd_sew)
            2'd0:    shift_in = SHIFT_WIDTH'(1);
            2'd1:    shift_in = SHIFT_WIDTH'(2);
            2'd2:    shift_in = SHIFT_WIDTH'(4);
            default: shift_in = '0;
        endcase
    end

    always_comb begin
        state_next   = state;
        cmd_ready    = 1'b0;
        rd_req_valid = 1'b0;
        rd_req_addr  = '0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_next = (cmd_vl != '0) ? ISSUE : DONE;
            end
            ISSUE: begin
                rd_req_valid = req_pending;
                if (req_pending)
                    rd_req_addr = src_q + REQ_ADDR_WIDTH'(req_cnt);
                if (req_fire && (req_cnt == nbeats_q - TB_W'(1)))
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (resp_cnt == nbeats_q)
                    state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            opsel_q   <= 1'b0;
            insert_q  <= 1'b0;
            shift_q   <= '0;
            off_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            scalar_q  <= '0;
            nbeats_q  <= '0;
            last_be_q <= '0;
            req_cnt   <= '0;
            resp_cnt  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                opsel_q   <= cmd_opsel;
                insert_q  <= cmd_insert;
                shift_q   <= shift_in;
                off_q     <= cmd_off;
                src_q     <= cmd_src_addr;
                dst_q     <= cmd_dst_addr;
                scalar_q  <= cmd_scalar;
                nbeats_q  <= nbeats_in;
                last_be_q <= last_be_in;
                req_cnt   <= '0;
                resp_cnt  <= '0;
            end else begin
                if (req_fire)
                    req_cnt <= req_cnt + TB_W'(1);
                if (resp_take)
                    resp_cnt <= resp_cnt + TB_W'(1);
            end
        end
    end

    // Beat bundle is fully zeroed on idle cycles so downstream can ignore sl_valid gating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sl_valid  <= 1'b0;
            sl_vec0   <= '0;
            sl_vec1   <= '0;
            sl_shift  <= '0;
            sl_start  <= 1'b0;
            sl_end    <= 1'b0;
            sl_opsel  <= 1'b0;
            sl_insert <= 1'b0;
            sl_addr   <= '0;
            sl_be     <= '0;
            sl_off    <= '0;
        end else if (resp_take) begin
            sl_valid  <= 1'b1;
            sl_vec0   <= rd_resp_data;
            sl_vec1   <= scalar_q;
            sl_shift  <= shift_q;
            sl_start  <= (resp_cnt == '0);
            sl_end    <= last_resp;
            sl_opsel  <= opsel_q;
            sl_insert <= insert_q;
            sl_addr   <= dst_q + REQ_ADDR_WIDTH'(resp_cnt);
            sl_be     <= last_resp ? last_be_q : {REQ_BYTE_EN_WIDTH{1'b1}};
            sl_off    <= off_q;
        end else begin
            sl_valid  <= 1'b0;
            sl_vec0   <= '0;
            sl_vec1   <= '0;
            sl_shift  <= '0;
            sl_start  <= 1'b0;
            sl_end    <= 1'b0;
            sl_opsel  <= 1'b0;
            sl_insert <= 1'b0;
            sl_addr   <= '0;
            sl_be     <= '0;
            sl_off    <= '0;
        end
    end

`ifdef VSLIDE_SEQ_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_stall_cnt <= '0;
        else if (accept)
            perf_stall_cnt <= '0;
        else if (req_pending && !rd_req_ready && (perf_stall_cnt != 32'hFFFF_FFFF))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_vslide_seq.sv
// tb/tb_vslide_seq.sv - randomized self-checking bench for vslide_seq against a beat-list reference model
`timescale 1ns/1ps
module tb_vslide_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_opsel, cmd_insert;
    logic [1:0]  cmd_sew;
    logic [11:0] cmd_vl, cmd_off;
    logic [31:0] cmd_src_addr, cmd_dst_addr;
    logic [63:0] cmd_scalar;
    logic        rd_req_valid, rd_req_ready;
    logic [31:0] rd_req_addr;
    logic        rd_resp_valid;
    logic [63:0] rd_resp_data;
    logic        sl_valid, sl_start, sl_end, sl_opsel, sl_insert, done;
    logic [63:0] sl_vec0, sl_vec1;
    logic [2:0]  sl_shift;
    logic [31:0] sl_addr;
    logic [7:0]  sl_be;
    logic [11:0] sl_off;
`ifdef VSLIDE_SEQ_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    vslide_seq dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opsel(cmd_opsel), .cmd_insert(cmd_insert),
        .cmd_sew(cmd_sew), .cmd_vl(cmd_vl), .cmd_off(cmd_off), .cmd_src_addr(cmd_src_addr),
        .cmd_dst_addr(cmd_dst_addr), .cmd_scalar(cmd_scalar),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
        .sl_valid(sl_valid), .sl_vec0(sl_vec0), .sl_vec1(sl_vec1), .sl_shift(sl_shift),
        .sl_start(sl_start), .sl_end(sl_end), .sl_opsel(sl_opsel), .sl_insert(sl_insert),
        .sl_addr(sl_addr), .sl_be(sl_be), .sl_off(sl_off), .done(done)
`ifdef VSLIDE_SEQ_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    typedef struct {
        logic [63:0] vec0, vec1;
        logic [2:0]  shift;
        logic        start, fin, opsel, insert;
        logic [31:0] addr;
        logic [7:0]  be;
        logic [11:0] off;
        int          neg;
    } beat_t;
    typedef struct {
        logic [63:0] data;
        int          due;
    } resp_t;

    beat_t       beats[$];
    logic [31:0] reqs[$];
    resp_t       pend[$];
    int          n_checks = 0, n_fail = 0;
    int          negcount = 0, done_cnt = 0, done_neg = 0, stalls = 0;
    int          ready_mode = 0, lat_lo = 1, lat_hi = 1;
    logic        inject = 1'b0;
    logic        pat [8];
    int          pat_len = 0, pat_gen = 0;
    int          pat_pos = 0, pat_seen = 0;
    logic        hold = 1'b0, rr;
    logic [31:0] held_addr;
    logic [31:0] seed;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_data(input logic [31:0] a);
        return {a ^ seed, a * 32'h9E37_79B1 + seed};
    endfunction

    // Beat monitor plus a memory model that answers reads in order after a random latency.
    always @(negedge clk) begin
        negcount++;
        if (sl_valid)
            beats.push_back('{sl_vec0, sl_vec1, sl_shift, sl_start, sl_end, sl_opsel, sl_insert,
                              sl_addr, sl_be, sl_off, negcount});
        else
            check("sl_idle_zero", 64'(|{sl_vec0, sl_vec1, sl_shift, sl_start, sl_end, sl_opsel,
                                        sl_insert, sl_addr, sl_be, sl_off}), 64'd0);
        if (done) begin
            done_cnt++;
            done_neg = negcount;
        end
        if (inject) begin
            rd_resp_valid = 1'b1;
            rd_resp_data  = 64'h55;
        end else if (pend.size() > 0 && pend[0].due <= negcount) begin
            rd_resp_valid = 1'b1;
            rd_resp_data  = pend[0].data;
            void'(pend.pop_front());
        end else begin
            rd_resp_valid = 1'b0;
            rd_resp_data  = {$urandom, $urandom};
        end
        if (pat_gen != pat_seen) begin
            pat_pos  = 0;
            pat_seen = pat_gen;
        end
        case (ready_mode)
            1:       rr = ($urandom_range(0, 3) != 0);
            2: begin
                if (rd_req_valid && pat_pos < pat_len) begin
                    rr = pat[pat_pos];
                    pat_pos++;
                end else rr = 1'b1;
            end
            default: rr = 1'b1;
        endcase
        rd_req_ready = rr;
        if (rd_req_valid) begin
            if (hold) check("req_addr_hold", 64'(rd_req_addr), 64'(held_addr));
            if (rr) begin
                reqs.push_back(rd_req_addr);
                pend.push_back('{mem_data(rd_req_addr), negcount + int'($urandom_range(lat_hi, lat_lo))});
                hold = 1'b0;
            end else begin
                stalls++;
                hold      = 1'b1;
                held_addr = rd_req_addr;
            end
        end else hold = 1'b0;
    end

    task automatic drive_junk();
        cmd_opsel    = 1'($urandom);
        cmd_insert   = 1'($urandom);
        cmd_sew      = 2'($urandom);
        cmd_vl       = 12'($urandom);
        cmd_off      = 12'($urandom);
        cmd_src_addr = $urandom;
        cmd_dst_addr = $urandom;
        cmd_scalar   = {$urandom, $urandom};
    endtask

    task automatic run_cmd(input logic opsel, input logic insert, input logic [1:0] sew, input logic [11:0] vl,
                           input logic [11:0] off, input logic [31:0] src, input logic [31:0] dst,
                           input logic [63:0] scalar);
        int b0, r0, d0, s0, total, n, t, acc, nb, nr;
        logic [7:0] lbe;
        logic [2:0] shift;
        beat_t b;
        b0 = beats.size(); r0 = reqs.size(); d0 = done_cnt; s0 = stalls;
        total = int'(vl) * (1 << sew);
        n     = (total + 7) / 8;
        lbe   = (total % 8 == 0) ? 8'hFF : 8'((1 << (total % 8)) - 1);
        shift = (sew == 2'd3) ? 3'd0 : 3'(1 << sew);
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_opsel = opsel; cmd_insert = insert; cmd_sew = sew; cmd_vl = vl;
        cmd_off = off; cmd_src_addr = src; cmd_dst_addr = dst; cmd_scalar = scalar;
        acc = negcount;
        @(negedge clk); #1;
        cmd_valid = 1'b0;
        drive_junk();
        check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
        t = 0;
        while (done_cnt == d0 && t < 6000) begin
            @(negedge clk); #1;
            t++;
        end
        check("done_seen", 64'(done_cnt - d0), 64'd1);
        @(negedge clk); #1;
        check("done_single", 64'(done_cnt - d0), 64'd1);
        check("cmd_ready_after", 64'(cmd_ready), 64'd1);
        nr = reqs.size() - r0;
        nb = beats.size() - b0;
        check("req_count", 64'(nr), 64'(n));
        for (int i = 0; i < n && i < nr; i++)
            check($sformatf("req%0d_addr", i), 64'(reqs[r0 + i]), 64'(src + 32'(i)));
        check("beat_count", 64'(nb), 64'(n));
        for (int i = 0; i < n && i < nb; i++) begin
            b = beats[b0 + i];
            check($sformatf("beat%0d_vec0", i), b.vec0, mem_data(src + 32'(i)));
            check($sformatf("beat%0d_vec1", i), b.vec1, scalar);
            check($sformatf("beat%0d_shift", i), 64'(b.shift), 64'(shift));
            check($sformatf("beat%0d_start", i), 64'(b.start), 64'(i == 0));
            check($sformatf("beat%0d_end", i), 64'(b.fin), 64'(i == n - 1));
            check($sformatf("beat%0d_op", i), 64'({b.opsel, b.insert}), 64'({opsel, insert}));
            check($sformatf("beat%0d_addr", i), 64'(b.addr), 64'(dst + 32'(i)));
            check($sformatf("beat%0d_be", i), 64'(b.be), 64'((i == n - 1) ? lbe : 8'hFF));
            check($sformatf("beat%0d_off", i), 64'(b.off), 64'(off));
        end
        if (n == 0)
            check("done_time", 64'(done_neg), 64'(acc + 1));
        else if (nb == n)
            check("done_time", 64'(done_neg), 64'(beats[b0 + n - 1].neg + 1));
`ifdef VSLIDE_SEQ_PERF_EN
        check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(stalls - s0));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, d0, t;
        seed = $urandom;
        rst = 1'b1;
        cmd_valid = 1'b0;
        drive_junk();
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_outputs", 64'(|{rd_req_valid, rd_req_addr, sl_valid, sl_vec0, sl_addr, sl_be, done}), 64'd0);
`ifdef VSLIDE_SEQ_PERF_EN
        check("rst_perf", 64'(perf_stall_cnt), 64'd0);
`endif
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;

        lat_lo = 2; lat_hi = 2; ready_mode = 0;
        run_cmd(1'b0, 1'b1, 2'd0, 12'd8, 12'd3, 32'h10, 32'h20, 64'hAB);
        lat_lo = 1; lat_hi = 3;
        run_cmd(1'b1, 1'b0, 2'd2, 12'd5, 12'd1, 32'h100, 32'h200, {$urandom, $urandom});

        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
        pat_len = 5; pat_gen++; ready_mode = 2; lat_lo = 1; lat_hi = 1;
        run_cmd(1'b0, 1'b0, 2'd3, 12'd3, 12'd0, 32'h400, 32'h800, {$urandom, $urandom});
`ifdef VSLIDE_SEQ_PERF_EN
        check("perf_toggle_two", 64'(perf_stall_cnt), 64'd2);
`endif
        ready_mode = 0;
        run_cmd(1'b1, 1'b1, 2'd1, 12'd0, 12'd7, 32'h40, 32'h50, {$urandom, $urandom});

        // Reset in the middle of a four-beat command.
        b0 = beats.size(); d0 = done_cnt;
        cmd_valid = 1'b1; cmd_opsel = 1'b0; cmd_insert = 1'b0; cmd_sew = 2'd3; cmd_vl = 12'd4;
        cmd_src_addr = 32'h1000; cmd_dst_addr = 32'h2000;
        @(negedge clk); #1;
        cmd_valid = 1'b0;
        t = 0;
        while (beats.size() - b0 < 2 && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        check("rst_mid_two_beats", 64'(beats.size() - b0), 64'd2);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", 64'(|{rd_req_valid, rd_req_addr, sl_valid, sl_vec0, sl_vec1, sl_shift,
                                       sl_start, sl_end, sl_opsel, sl_insert, sl_addr, sl_be, sl_off, done}), 64'd0);
        check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk); #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("rst_mid_no_more_beats", 64'(beats.size() - b0), 64'd2);
        check("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
        run_cmd(1'b1, 1'b0, 2'd0, 12'd9, 12'd2, 32'h3000, 32'h4000, {$urandom, $urandom});

        // Stray response while idle must be ignored.
        b0 = beats.size();
        inject = 1'b1;
        @(negedge clk); #1 inject = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("idle_resp_no_beat", 64'(beats.size() - b0), 64'd0);
        check("idle_resp_ready", 64'(cmd_ready), 64'd1);
        run_cmd(1'b0, 1'b1, 2'd0, 12'd1, 12'd0, 32'h77, 32'h88, {$urandom, $urandom});

        for (int k = 0; k < 24; k++) begin
            ready_mode = int'($urandom_range(0, 1));
            lat_lo = 1;
            lat_hi = int'($urandom_range(1, 4));
            run_cmd(1'($urandom), 1'($urandom), 2'($urandom), 12'($urandom_range(0, 40)), 12'($urandom),
                    $urandom, $urandom, {$urandom, $urandom});
        end

        ready_mode = 0; lat_lo = 1; lat_hi = 1;
        run_cmd(1'b1, 1'b1, 2'd3, 12'hFFF, 12'hFFF, 32'hFFFF_F000, 32'h0, {$urandom, $urandom});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
